// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding and defaults.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: lowest requesting index at or above rr_ptr, else wrap to the
// lowest requesting index overall.
module rr_priority_pick #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned IDX_WIDTH = 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any_req
);

    always_comb begin
        grant   = '0;
        any_req = |req;
        // Wrap pass first; the at-or-above-pointer pass overrides it when it finds a hit.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = IDX_WIDTH'(i);
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(rr_ptr))) begin
                grant = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CORES cores,
// one transaction at a time, with a memory-response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned IDX_WIDTH  = 1,
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*MEM_WIDTH-1:0]  core_wdata,
    output logic [NUM_CORES-1:0]            core_ack,
    output logic                            core_err,
    output logic [MEM_WIDTH-1:0]            core_rdata,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_read_en,
    output logic                            mem_write_en,
    output logic [MEM_WIDTH-1:0]            mem_write_val,
    input  logic [MEM_WIDTH-1:0]            mem_read_val,
    input  logic                            mem_ready,
    output logic [IDX_WIDTH-1:0]            grant_id,
    output logic                            busy
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [MEM_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [IDX_WIDTH-1:0]  pick_grant;
    logic                  pick_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [MEM_WIDTH-1:0]  sel_wdata;
    logic                  sel_we;

    rr_priority_pick #(
        .NUM_CORES(NUM_CORES),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_pick (
        .req    (core_req),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .any_req(pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_grant == IDX_WIDTH'(i)) begin
                sel_addr  = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = core_wdata[i*MEM_WIDTH +: MEM_WIDTH];
                sel_we    = core_we[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A response arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    rdata_d = mem_read_val;
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_RESP: begin
                rr_ptr_d = (grant_q == IDX_WIDTH'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        core_ack = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_ack[i] = (state_q == ARB_RESP) && (grant_q == IDX_WIDTH'(i));
        end
    end

    assign core_err      = err_q;
    assign core_rdata    = rdata_q;
    assign mem_addr      = addr_q;
    assign mem_write_val = wdata_q;
    assign mem_read_en   = (state_q == ARB_BUSY) && !we_q;
    assign mem_write_en  = (state_q == ARB_BUSY) && we_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int NC = 2;
    localparam int AW = 32;
    localparam int MW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    core_req;
    logic [1:0]    core_we;
    logic [63:0]   core_addr;
    logic [63:0]   core_wdata;
    logic [1:0]    core_ack;
    logic          core_err;
    logic [31:0]   core_rdata;
    logic [31:0]   mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [31:0]   mem_write_val;
    logic [31:0]   mem_read_val;
    logic          mem_ready;
    logic [0:0]    grant_id;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b1;

    mem_port_arbiter #(
        .NUM_CORES (NC),
        .IDX_WIDTH (1),
        .MEM_WIDTH (MW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_ack     (core_ack),
        .core_err     (core_err),
        .core_rdata   (core_rdata),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_write_val(mem_write_val),
        .mem_read_val (mem_read_val),
        .mem_ready    (mem_ready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: a transaction is in flight, or its response is being
    // returned, or nothing is happening.
    bit          m_in_flight = 1'b0;
    bit          m_responding = 1'b0;
    int          m_waited = 0;
    int          m_core = 0;
    int          m_next_first = 0;
    bit          m_is_write = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_in_flight  = 1'b0;
            m_responding = 1'b0;
            m_waited     = 0;
            m_core       = 0;
            m_next_first = 0;
            m_is_write   = 1'b0;
            m_err        = 1'b0;
            m_addr       = '0;
            m_wdata      = '0;
            m_rdata      = '0;
        end else if (m_responding) begin
            m_responding = 1'b0;
            m_next_first = (m_core + 1) % NC;
        end else if (m_in_flight) begin
            if (mem_ready) begin
                m_rdata      = mem_read_val;
                m_err        = 1'b0;
                m_in_flight  = 1'b0;
                m_responding = 1'b1;
            end else if (m_waited + 1 == TO) begin
                m_rdata      = '0;
                m_err        = 1'b1;
                m_in_flight  = 1'b0;
                m_responding = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (core_req != 2'b00) begin
            for (int k = 0; k < NC; k++) begin
                if (core_req[(m_next_first + k) % NC]) begin
                    m_core = (m_next_first + k) % NC;
                    break;
                end
            end
            m_addr      = core_addr[m_core*AW +: AW];
            m_wdata     = core_wdata[m_core*MW +: MW];
            m_is_write  = core_we[m_core];
            m_waited    = 0;
            m_in_flight = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_in_flight || m_responding);
            check("mem_read_en", mem_read_en, m_in_flight && !m_is_write);
            check("mem_write_en", mem_write_en, m_in_flight && m_is_write);
            check("mem_addr", mem_addr, m_addr);
            check("mem_write_val", mem_write_val, m_wdata);
            check("grant_id", grant_id, m_core);
            check("core_ack", core_ack, m_responding ? (64'd1 << m_core) : 64'd0);
            check("core_err", core_err, m_err);
            check("core_rdata", core_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (core_ack == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        check("ack_within_budget", core_ack != 2'b00, 1);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    int n;
    int last_cyc;
    int wr_cycles;

    initial begin
        core_req     = '0;
        core_we      = '0;
        core_addr    = '0;
        core_wdata   = '0;
        mem_read_val = '0;
        mem_ready    = 1'b0;
        apply_reset();

        check("reset_busy", busy, 0);
        check("reset_ack", core_ack, 0);
        check("reset_grant", grant_id, 0);

        // mem_ready with no transaction is ignored
        mem_ready = 1'b1;
        repeat (3) tick();
        check("idle_ready_busy", busy, 0);
        check("idle_ready_ack", core_ack, 0);
        mem_ready = 1'b0;

        // Single zero-wait read by core 0
        core_addr[31:0] = 32'h10;
        mem_read_val    = 32'hDEADBEEF;
        mem_ready       = 1'b1;
        core_req        = 2'b01;
        tick();
        check("t1_read_en", mem_read_en, 1);
        check("t1_addr", mem_addr, 32'h10);
        tick();
        check("t1_ack", core_ack, 2'b01);
        check("t1_rdata", core_rdata, 32'hDEADBEEF);
        check("t1_err", core_err, 0);
        check("t1_grant", grant_id, 0);
        check("t1_read_en_off", mem_read_en, 0);
        core_req  = 2'b00;
        mem_ready = 1'b0;
        tick();
        check("t1_idle", busy, 0);

        // Contention from reset: grants alternate, ack every 3 cycles
        apply_reset();
        core_addr    = {32'h200, 32'h100};
        mem_read_val = 32'h0BADF00D;
        mem_ready    = 1'b1;
        core_req     = 2'b11;
        last_cyc     = 0;
        for (int a = 0; a < 4; a++) begin
            wait_ack(10, n);
            check("t2_grant_seq", grant_id, a % 2);
            check("t2_ack_seq", core_ack, (a % 2 == 0) ? 2'b01 : 2'b10);
            if (a > 0) check("t2_spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
            if (a == 3) begin
                core_req  = 2'b00;
                mem_ready = 1'b0;
            end
            tick();
        end

        // Core 1 write with four wait cycles
        core_req            = 2'b10;
        core_we             = 2'b10;
        core_addr[63:32]    = 32'h40;
        core_wdata[63:32]   = 32'h12345678;
        mem_read_val        = 32'hA5A50001;
        tick();
        wr_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            check("t3_write_en", mem_write_en, 1);
            check("t3_read_en", mem_read_en, 0);
            check("t3_addr", mem_addr, 32'h40);
            check("t3_wdata", mem_write_val, 32'h12345678);
            wr_cycles += int'(mem_write_en);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("t3_ack", core_ack, 2'b10);
        check("t3_write_en_off", mem_write_en, 0);
        check("t3_write_cycles", wr_cycles, 4);
        core_req  = 2'b00;
        core_we   = 2'b00;
        mem_ready = 1'b0;
        tick();

        // Timeout on core 0: ack in the 9th cycle after the request was sampled
        core_req        = 2'b01;
        core_addr[31:0] = 32'h80;
        tick();
        wait_ack(20, n);
        check("t4_latency", n, 8);
        check("t4_ack", core_ack, 2'b01);
        check("t4_err", core_err, 1);
        check("t4_rdata", core_rdata, 0);
        core_req = 2'b00;
        tick();
        // Next request served normally
        core_req     = 2'b10;
        mem_read_val = 32'h00000055;
        mem_ready    = 1'b1;
        tick();
        tick();
        check("t4b_ack", core_ack, 2'b10);
        check("t4b_err", core_err, 0);
        check("t4b_rdata", core_rdata, 32'h55);
        core_req  = 2'b00;
        mem_ready = 1'b0;
        tick();

        // Asynchronous reset while BUSY
        core_req = 2'b01;
        tick();
        check("t5_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_read_en", mem_read_en, 0);
        check("t5_rst_write_en", mem_write_en, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_wval", mem_write_val, 0);
        check("t5_rst_ack", core_ack, 0);
        check("t5_rst_err", core_err, 0);
        check("t5_rst_rdata", core_rdata, 0);
        check("t5_rst_grant", grant_id, 0);
        core_req  = 2'b10;
        mem_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("t5_grant", grant_id, 1);
        tick();
        check("t5_ack", core_ack, 2'b10);
        core_req  = 2'b00;
        mem_ready = 1'b0;
        tick();

        // Core 0 drops req during BUSY; transaction still completes
        core_req = 2'b01;
        tick();
        tick();
        core_req = 2'b00;
        tick();
        tick();
        mem_ready = 1'b1;
        wait_ack(5, n);
        check("t6_ack", core_ack, 2'b01);
        check("t6_err", core_err, 0);
        mem_ready = 1'b0;
        tick();
        tick();
        check("t6_idle", busy, 0);
        tick();
        check("t6_no_grant", busy, 0);

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
